uart_frame_check: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_check_sat_counter.sv | 22 ++
 rtl/uart_frame_check.sv | 157 +++++++++++++++
 tb/tb_uart_frame_check.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame-integrity checker.
package uart_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP1  = 3'd3;
  localparam logic [2:0] ST_STOP2  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP1  = ST_STOP1,
    STOP2  = ST_STOP2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_frame_check_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a simultaneous increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_frame_check.sv
// UART frame checker: tracks data/parity/stop position and reports per-frame errors.
// Optional break detection is built when UART_FRAME_CHK_BREAK_EN is defined.
module uart_frame_check
  import uart_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 bit_vld,
  input  logic                 sampled_bit,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic                 stp_num,
  input  logic                 err_clr,
  output logic                 frame_done,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stp_err_cnt
`ifdef UART_FRAME_CHK_BREAK_EN
  ,
  output logic                 brk_det
`endif
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_t         state;
  logic           cfg_par_en;
  logic           cfg_par_typ;
  logic           cfg_stp_num;
  logic [BCW-1:0] bit_cnt;
  logic           par_acc;
  logic           frm_par_err;
  logic           frm_stp_err;

  logic last_bit;
  logic fin_par;
  logic fin_stp;
  logic stp_eff;

  // The frame completes on the strobe of its final stop bit; a restart suppresses it.
  assign last_bit = bit_vld && !frame_start &&
                    (((state == STOP1) && !cfg_stp_num) || (state == STOP2));
  assign fin_par  = cfg_par_en & frm_par_err;
  assign fin_stp  = (state == STOP2) ? (frm_stp_err | ~sampled_bit) : ~sampled_bit;
  assign busy     = (state != IDLE);

`ifdef UART_FRAME_CHK_BREAK_EN
  logic nonzero;
  logic frm_brk;
  logic fin_brk;

  assign fin_brk = (state == STOP2) ? frm_brk : (~nonzero & ~sampled_bit);
  assign stp_eff = fin_stp & ~fin_brk;

  // A break is an all-zero frame up to and including the first stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      nonzero <= 1'b0;
      frm_brk <= 1'b0;
      brk_det <= 1'b0;
    end else begin
      if (frame_start) begin
        nonzero <= 1'b0;
        frm_brk <= 1'b0;
      end else if (bit_vld) begin
        if ((state == DATA) || (state == PARITY)) begin
          nonzero <= nonzero | sampled_bit;
        end else if (state == STOP1) begin
          frm_brk <= ~nonzero & ~sampled_bit;
        end
      end
      if (last_bit) begin
        brk_det <= fin_brk;
      end
    end
  end
`else
  assign stp_eff = fin_stp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      cfg_stp_num <= 1'b0;
      bit_cnt     <= '0;
      par_acc     <= 1'b0;
      frm_par_err <= 1'b0;
      frm_stp_err <= 1'b0;
      frame_done  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        state       <= DATA;
        cfg_par_en  <= par_en;
        cfg_par_typ <= par_typ;
        cfg_stp_num <= stp_num;
        bit_cnt     <= '0;
        par_acc     <= 1'b0;
        frm_par_err <= 1'b0;
        frm_stp_err <= 1'b0;
      end else if (bit_vld) begin
        case (state)
          DATA: begin
            par_acc <= par_acc ^ sampled_bit;
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= cfg_par_en ? PARITY : STOP1;
            end
          end
          PARITY: begin
            frm_par_err <= ((par_acc ^ sampled_bit) != cfg_par_typ);
            state       <= STOP1;
          end
          STOP1: begin
            frm_stp_err <= ~sampled_bit;
            state       <= cfg_stp_num ? STOP2 : IDLE;
          end
          STOP2:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      if (last_bit) begin
        frame_done <= 1'b1;
        par_err    <= fin_par;
        stp_err    <= stp_eff;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (last_bit & fin_par),
    .clr   (err_clr),
    .count (par_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (last_bit & stp_eff),
    .clr   (err_clr),
    .count (stp_err_cnt)
  );

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: directed table, randomized frames against a frame-level model,
// and hand-written abort / reset sequences. Follows UART_FRAME_CHK_BREAK_EN when defined.
module tb_uart_frame_check;
  import uart_frame_pkg::*;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [7:0] data;
    logic       pbit, s1, s2, pe, pt, sn, clr;
    logic       ep, es, eb;
    int         pc, sc;
  } vec_t;

  logic clk = 1'b0;
  logic rst, frame_start, bit_vld, sampled_bit, par_en, par_typ, stp_num, err_clr;
  logic frame_done, par_err, stp_err, busy;
  logic [CW-1:0] par_err_cnt, stp_err_cnt;
`ifdef UART_FRAME_CHK_BREAK_EN
  logic brk_det;
`endif

  int n_checks = 0, n_pass = 0, done_cnt = 0, exp_done = 0, m_pc = 0, m_sc = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

  uart_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bit_vld     (bit_vld),
    .sampled_bit (sampled_bit),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .stp_num     (stp_num),
    .err_clr     (err_clr),
    .frame_done  (frame_done),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
`ifdef UART_FRAME_CHK_BREAK_EN
    ,
    .brk_det     (brk_det)
`endif
  );

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic pb, s1, s2, pe, pt, sn, clr,
                              input logic ep, es, eb, input int pc, sc);
    vec_t v;
    v.data = d; v.pbit = pb; v.s1 = s1; v.s2 = s2; v.pe = pe; v.pt = pt; v.sn = sn;
    v.clr = clr; v.ep = ep; v.es = es; v.eb = eb; v.pc = pc; v.sc = sc;
    return v;
  endfunction

  // Frame-level reference: error flags from the bit values, counters as saturating tallies.
  task automatic model(inout vec_t v);
    logic brk, stop_bad;
    v.ep     = v.pe && ((($countones(v.data) + int'(v.pbit)) % 2) != int'(v.pt));
    brk      = (v.data == 8'h00) && (!v.pe || !v.pbit) && !v.s1;
    stop_bad = !v.s1 || (v.sn && !v.s2);
`ifdef UART_FRAME_CHK_BREAK_EN
    v.es = stop_bad && !brk;
    v.eb = brk;
`else
    v.es = stop_bad;
    v.eb = 1'b0;
`endif
    m_pc = v.clr ? 0 : ((m_pc + int'(v.ep) > CMAX) ? CMAX : m_pc + int'(v.ep));
    m_sc = v.clr ? 0 : ((m_sc + int'(v.es) > CMAX) ? CMAX : m_sc + int'(v.es));
    v.pc = m_pc;
    v.sc = m_sc;
  endtask

  task automatic send_bit(input logic b, input logic clr, input int gap);
    bit_vld = 1'b1; sampled_bit = b; err_clr = clr;
    @(negedge clk);
    bit_vld = 1'b0; err_clr = 1'b0; sampled_bit = 1'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Inputs other than frame_start are scrambled around the start to prove cfg is latched.
  task automatic start_frame(input logic pe, pt, sn);
    frame_start = 1'b1; par_en = pe; par_typ = pt; stp_num = sn;
    bit_vld = 1'($urandom); sampled_bit = 1'($urandom);
    @(negedge clk);
    frame_start = 1'b0; bit_vld = 1'b0;
    par_en = 1'($urandom); par_typ = 1'($urandom); stp_num = 1'($urandom);
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    start_frame(v.pe, v.pt, v.sn);
    check_output($sformatf("%s busy_mid", tag), busy, 1);
    for (int i = 0; i < DW; i++) send_bit(v.data[i], 1'b0, $urandom_range(0, 2));
    if (v.pe) send_bit(v.pbit, 1'b0, $urandom_range(0, 2));
    if (v.sn) begin
      send_bit(v.s1, 1'b0, $urandom_range(0, 2));
      send_bit(v.s2, v.clr, 0);
    end else begin
      send_bit(v.s1, v.clr, 0);
    end
    exp_done++;
    check_output($sformatf("%s frame_done", tag), frame_done, 1);
    check_output($sformatf("%s par_err", tag), par_err, v.ep);
    check_output($sformatf("%s stp_err", tag), stp_err, v.es);
    check_output($sformatf("%s par_err_cnt", tag), par_err_cnt, v.pc);
    check_output($sformatf("%s stp_err_cnt", tag), stp_err_cnt, v.sc);
`ifdef UART_FRAME_CHK_BREAK_EN
    check_output($sformatf("%s brk_det", tag), brk_det, v.eb);
`endif
    @(negedge clk);
    check_output($sformatf("%s done_pulse_width", tag), frame_done, 0);
    check_output($sformatf("%s busy_end", tag), busy, 0);
    check_output($sformatf("%s done_count", tag), done_cnt, exp_done);
    repeat ($urandom_range(0, 3)) begin
      bit_vld = 1'($urandom); sampled_bit = 1'($urandom);
      @(negedge clk);
    end
    bit_vld = 1'b0;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; frame_start = 1'b0; bit_vld = 1'b0; sampled_bit = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stp_num = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_output("reset frame_done", frame_done, 0);
    check_output("reset par_err", par_err, 0);
    check_output("reset stp_err", stp_err, 0);
    check_output("reset busy", busy, 0);
    check_output("reset par_err_cnt", par_err_cnt, 0);
    check_output("reset stp_err_cnt", stp_err_cnt, 0);

    //              data   pb    s1    s2    pe    pt        sn    clr   ep    es    eb   pc sc
    tbl[0]  = mk(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[1]  = mk(8'h07, 1'b0, 1'b1, 1'b1, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    tbl[2]  = mk(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[3]  = mk(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
    tbl[4]  = mk(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2);
    tbl[5]  = mk(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3);
    tbl[6]  = mk(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3);
    tbl[7]  = mk(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3);
    tbl[8]  = mk(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
`ifdef UART_FRAME_CHK_BREAK_EN
    tbl[9]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    tbl[10] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, PAR_ODD,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    tbl[11] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
`else
    tbl[9]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
    tbl[10] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, PAR_ODD,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    tbl[11] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2);
`endif
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i], $sformatf("row%0d", i));
      m_pc = tbl[i].pc;
      m_sc = tbl[i].sc;
    end

    // Abort after four data bits, then a clean frame: only one completion, counters unchanged.
    start_frame(1'b1, PAR_ODD, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1);
    check_output("abort no_done", done_cnt, exp_done);
    v = mk(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    model(v);
    apply_stimulus(v, "abort_restart");

    for (int n = 0; n < 40; n++) begin
      v.data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      v.pbit = 1'($urandom);
      v.s1   = ($urandom_range(0, 3) != 0);
      v.s2   = ($urandom_range(0, 3) != 0);
      v.pe   = 1'($urandom);
      v.pt   = 1'($urandom);
      v.sn   = 1'($urandom);
      v.clr  = ($urandom_range(0, 7) == 0);
      model(v);
      apply_stimulus(v, $sformatf("rand%0d", n));
    end

    // Reset mid-frame clears everything and produces no completion.
    start_frame(1'b1, PAR_EVEN, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst busy", busy, 0);
    check_output("midrst par_err", par_err, 0);
    check_output("midrst stp_err", stp_err, 0);
    check_output("midrst par_err_cnt", par_err_cnt, 0);
    check_output("midrst stp_err_cnt", stp_err_cnt, 0);
    check_output("midrst done_count", done_cnt, exp_done);
    m_pc = 0;
    m_sc = 0;
    v = mk(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, PAR_ODD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    model(v);
    apply_stimulus(v, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
